input_vc_buffer: RTL



---
 rtl/input_vc_buffer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/input_vc_buffer.sv
// Per-VC router input stage: flit FIFO plus IDLE/VA/ACTIVE packet tracker feeding VC and switch allocation.
// Define IBUF_ERR_CHECK_EN to build the sticky protocol-error flag; otherwise error_o is tied low.
module input_vc_buffer #(
   parameter int BUFFER_SIZE = 8,
   parameter int VC_SIZE     = 1,
   parameter int DATA_SIZE   = 32,
   parameter int FLIT_SIZE   = 2 + 3 + VC_SIZE + DATA_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FLIT_SIZE-1:0] data_i,
   input  logic                 valid_flit_i,
   input  logic                 read_i,
   input  logic [VC_SIZE-1:0]   vc_new_i,
   input  logic                 vc_valid_i,
   output logic                 vc_request_o,
   output logic [2:0]           out_port_o,
   output logic                 switch_request_o,
   output logic [FLIT_SIZE-1:0] data_o,
   output logic                 is_full_o,
   output logic                 is_empty_o,
   output logic                 error_o
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = PTR_W + 1;
   localparam int VC_LSB = DATA_SIZE;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   localparam logic [1:0] HEAD     = 2'b00;
   localparam logic [1:0] TAIL     = 2'b10;
   localparam logic [1:0] HEADTAIL = 2'b11;
   localparam logic [2:0] LOCAL    = 3'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VA     = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   function automatic logic opens_packet(input logic [1:0] t);
      return (t == HEAD) || (t == HEADTAIL);
   endfunction

   function automatic logic closes_packet(input logic [1:0] t);
      return (t == TAIL) || (t == HEADTAIL);
   endfunction

   function automatic logic [1:0] flit_type(input logic [FLIT_SIZE-1:0] f);
      return f[FLIT_SIZE-1 -: 2];
   endfunction

   function automatic logic [2:0] flit_port(input logic [FLIT_SIZE-1:0] f);
      return f[FLIT_SIZE-3 -: 3];
   endfunction

   logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   state_t               state_q, state_d;
   logic [2:0]           out_port_q, out_port_d;
   logic [VC_SIZE-1:0]   vc_down_q, vc_down_d;
   logic                 full_s, empty_s, wr_en_s, pop_en_s;
   logic [FLIT_SIZE-1:0] head_s, next_head_s, data_s;

   assign full_s      = (count_q == FULL_CNT);
   assign empty_s     = (count_q == CNT_ZERO);
   assign pop_en_s    = read_i && (state_q == ACTIVE) && !empty_s;
   // A pop frees the slot the write needs, so a full FIFO still accepts a flit on a pop cycle.
   assign wr_en_s     = valid_flit_i && (!full_s || pop_en_s);
   assign head_s      = mem_q[rd_ptr_q];
   assign next_head_s = mem_q[rd_ptr_q + PTR_ONE];

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_en_s  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({wr_en_s, pop_en_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Packet state machine: out-port capture, downstream VC latch, end-of-packet handover.
   always_comb begin
      state_d    = state_q;
      out_port_d = out_port_q;
      vc_down_d  = vc_down_q;
      case (state_q)
         IDLE: begin
            if (wr_en_s && opens_packet(flit_type(data_i))) begin
               state_d    = VA;
               out_port_d = flit_port(data_i);
            end else begin
               state_d    = IDLE;
            end
         end
         VA: begin
            if (vc_valid_i) begin
               state_d   = ACTIVE;
               vc_down_d = vc_new_i;
            end else begin
               state_d   = VA;
            end
         end
         ACTIVE: begin
            if (pop_en_s && closes_packet(flit_type(head_s))) begin
               // The following head is either already queued or arriving into an emptied FIFO now.
               if (count_q > CNT_ONE) begin
                  if (opens_packet(flit_type(next_head_s))) begin
                     state_d    = VA;
                     out_port_d = flit_port(next_head_s);
                  end else begin
                     state_d    = IDLE;
                     out_port_d = LOCAL;
                  end
               end else if (wr_en_s && opens_packet(flit_type(data_i))) begin
                  state_d    = VA;
                  out_port_d = flit_port(data_i);
               end else begin
                  state_d    = IDLE;
                  out_port_d = LOCAL;
               end
            end else begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d    = IDLE;
            out_port_d = LOCAL;
         end
      endcase
   end

   // Head flit with its VC field rewritten to the granted downstream VC.
   always_comb begin
      data_s = {FLIT_SIZE{1'b0}};
      if ((state_q == ACTIVE) && !empty_s) begin
         data_s = head_s;
         data_s[VC_LSB +: VC_SIZE] = vc_down_q;
      end else begin
         data_s = {FLIT_SIZE{1'b0}};
      end
   end

   // Control registers; reset drops every stored flit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         count_q    <= CNT_ZERO;
         state_q    <= IDLE;
         out_port_q <= LOCAL;
         vc_down_q  <= {VC_SIZE{1'b0}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         out_port_q <= out_port_d;
         vc_down_q  <= vc_down_d;
      end
   end

   // Flit storage.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign vc_request_o     = (state_q == VA);
   assign switch_request_o = (state_q == ACTIVE) && !empty_s;
   assign out_port_o       = out_port_q;
   assign data_o           = data_s;
   assign is_full_o        = full_s;
   assign is_empty_o       = empty_s;

`ifdef IBUF_ERR_CHECK_EN
   logic pkt_open_q, pkt_open_d, error_q, err_event_s;
   logic [1:0] in_type_s;

   assign in_type_s = flit_type(data_i);

   // Write-side tracking of whether the newest packet still awaits its tail.
   always_comb begin
      pkt_open_d = pkt_open_q;
      if (wr_en_s && (in_type_s == HEAD)) begin
         pkt_open_d = 1'b1;
      end else if (wr_en_s && closes_packet(in_type_s)) begin
         pkt_open_d = 1'b0;
      end else begin
         pkt_open_d = pkt_open_q;
      end
   end

   assign err_event_s = (valid_flit_i && full_s && !pop_en_s)
                     || (valid_flit_i && (state_q == IDLE) && !opens_packet(in_type_s))
                     || (valid_flit_i && (state_q != IDLE) && opens_packet(in_type_s) && pkt_open_q);

   // Sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_open_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         pkt_open_q <= pkt_open_d;
         error_q    <= error_q | err_event_s;
         if (err_event_s) begin
            $error("input_vc_buffer: protocol error (type %b, state %0d, count %0d)",
                   in_type_s, state_q, count_q);
         end
      end
   end

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule
